// File: rtl/tlc_pkg.sv
// Shared definitions for the intersection controller: state codes, lamp
// codes, timer duration selectors and the state-to-lamp decode.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_AR1   = 3'd0,
    ST_NSG   = 3'd1,
    ST_NSY   = 3'd2,
    ST_AR2   = 3'd3,
    ST_EWG   = 3'd4,
    ST_EWY   = 3'd5,
    ST_FLASH = 3'd6
  } tlc_state_e;

  // Which phase length the timer should terminate on
  typedef enum logic [2:0] {
    DUR_GREEN  = 3'd0,
    DUR_YELLOW = 3'd1,
    DUR_ALLRED = 3'd2,
    DUR_PED    = 3'd3,
    DUR_FLASH  = 3'd4
  } dur_sel_e;

  // Lamp codes, bit order {R,Y,G}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } lamps_t;

  function automatic logic is_allred(input tlc_state_e st);
    return (st == ST_AR1) || (st == ST_AR2);
  endfunction

  // Both directions default to red; only the served direction changes,
  // except in FLASH where both blink yellow together.
  function automatic lamps_t decode_lamps(input tlc_state_e st, input logic blink);
    lamps_t l;
    l.ns = LAMP_R;
    l.ew = LAMP_R;
    case (st)
      ST_NSG:   l.ns = LAMP_G;
      ST_NSY:   l.ns = LAMP_Y;
      ST_EWG:   l.ew = LAMP_G;
      ST_EWY:   l.ew = LAMP_Y;
      ST_FLASH: begin
        l.ns = blink ? LAMP_Y : LAMP_OFF;
        l.ew = blink ? LAMP_Y : LAMP_OFF;
      end
      default:  ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts cycles spent in the current phase and flags the last
// cycle of the selected duration. clr restarts the count at 0.
module tlc_phase_timer
  import tlc_pkg::*;
#(
  parameter int CW       = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 6,
  parameter int FLASH_T  = 4
) (
  input  logic          ck,
  input  logic          rs,
  input  logic          clr,
  input  dur_sel_e      dur,
  output logic [CW-1:0] count,
  output logic          tc
);

  // Every duration's last count (duration-1) must be representable in CW bits
  localparam bit DURS_OK =
    (GREEN_T  >= 1) && (GREEN_T  <= (1 << CW)) &&
    (YELLOW_T >= 1) && (YELLOW_T <= (1 << CW)) &&
    (ALLRED_T >= 1) && (ALLRED_T <= (1 << CW)) &&
    (PED_T    >= 1) && (PED_T    <= (1 << CW)) &&
    (FLASH_T  >= 1) && (FLASH_T  <= (1 << CW));

  if (!DURS_OK) begin : g_bad_durations
    $error("tlc_phase_timer: every duration must lie in 1..2**CW");
  end

  localparam logic [CW-1:0] TC_GREEN  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] TC_YELLOW = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] TC_ALLRED = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] TC_PED    = CW'(PED_T - 1);
  localparam logic [CW-1:0] TC_FLASH  = CW'(FLASH_T - 1);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] tc_val;

  // Pick the terminal count of the phase being timed
  always_comb begin
    tc_val = TC_ALLRED;
    case (dur)
      DUR_GREEN:  tc_val = TC_GREEN;
      DUR_YELLOW: tc_val = TC_YELLOW;
      DUR_ALLRED: tc_val = TC_ALLRED;
      DUR_PED:    tc_val = TC_PED;
      DUR_FLASH:  tc_val = TC_FLASH;
      default:    tc_val = TC_ALLRED;
    endcase
  end

  // Advance every cycle, restart on clr
  always_comb begin
    count_d = count_q + 1'b1;
    if (clr) begin
      count_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge ck) begin
    if (rs) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == tc_val);

endmodule

// File: rtl/tlc_intersection.sv
// Two-way intersection controller with pedestrian all-red service and a
// night-time flashing-yellow mode.
module tlc_intersection
  import tlc_pkg::*;
#(
  parameter int CW       = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 6,
  parameter int FLASH_T  = 4
) (
  input  logic          ck,
  input  logic          rs,
  input  logic          ped_req,
  input  logic          night,
  output logic [2:0]    light_ns,
  output logic [2:0]    light_ew,
  output logic          walk,
  output logic [2:0]    state,
  output logic [CW-1:0] counter
);

  tlc_state_e    state_q, state_d;
  logic          pend_q, pend_d;    // pedestrian request waiting for an all-red
  logic          serve_q, serve_d;  // current all-red is serving a crossing
  logic          blink_q, blink_d;  // flashing-mode lamp phase
  logic          clr;
  logic          tc;
  dur_sel_e      dur;
  logic [CW-1:0] count;
  lamps_t        lamps;

  // Duration the timer should apply to the current state
  always_comb begin
    dur = DUR_ALLRED;
    case (state_q)
      ST_AR1, ST_AR2: dur = serve_q ? DUR_PED : DUR_ALLRED;
      ST_NSG, ST_EWG: dur = DUR_GREEN;
      ST_NSY, ST_EWY: dur = DUR_YELLOW;
      ST_FLASH:       dur = DUR_FLASH;
      default:        dur = DUR_ALLRED;
    endcase
  end

  tlc_phase_timer #(
    .CW       (CW),
    .GREEN_T  (GREEN_T),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .PED_T    (PED_T),
    .FLASH_T  (FLASH_T)
  ) u_timer (
    .ck    (ck),
    .rs    (rs),
    .clr   (clr),
    .dur   (dur),
    .count (count),
    .tc    (tc)
  );

  // Next state, pedestrian bookkeeping, blink phase and timer restart
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | ped_req;
    serve_d = serve_q;
    blink_d = blink_q;
    clr     = 1'b0;

    case (state_q)
      ST_AR1:   if (tc) state_d = night ? ST_FLASH : ST_NSG;
      ST_NSG:   if (night || tc) state_d = ST_NSY;
      ST_NSY:   if (tc) state_d = ST_AR2;
      ST_AR2:   if (tc) state_d = night ? ST_FLASH : ST_EWG;
      ST_EWG:   if (night || tc) state_d = ST_EWY;
      ST_EWY:   if (tc) state_d = ST_AR1;
      ST_FLASH: begin
        if (!night) begin
          state_d = ST_AR1;
        end else if (tc) begin
          // blink half-period elapsed: wrap the counter, stay in FLASH
          clr     = 1'b1;
          blink_d = ~blink_q;
        end
      end
      default:  state_d = ST_AR1;
    endcase

    if (state_d != state_q) begin
      clr     = 1'b1;
      serve_d = 1'b0;
      // An all-red entered with a request outstanding (including one arriving
      // this very cycle) serves the crossing; a request on the entry cycle
      // also stays pending for the next all-red.
      if (is_allred(state_d)) begin
        serve_d = pend_q | ped_req;
        pend_d  = ped_req;
      end
      if (state_d == ST_FLASH) begin
        pend_d  = ped_req;
        blink_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge ck) begin
    if (rs) begin
      state_q <= ST_AR1;
      pend_q  <= 1'b0;
      serve_q <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      serve_q <= serve_d;
      blink_q <= blink_d;
    end
  end

  // Outputs decode straight from registered state; reset forces all-red
  assign lamps    = decode_lamps(state_q, blink_q);
  assign light_ns = rs ? LAMP_R : lamps.ns;
  assign light_ew = rs ? LAMP_R : lamps.ew;
  assign walk     = ~rs & serve_q & is_allred(state_q);
  assign state    = state_q;
  assign counter  = count;

endmodule

// File: tb/tb_tlc_intersection.sv
// Bench for tlc_intersection: phase-level reference model compared every
// cycle, plus directed scenarios with literal phase lengths and lamp values.
module tb_tlc_intersection;
  import tlc_pkg::*;

  localparam int CW       = 4;
  localparam int GREEN_T  = 8;
  localparam int YELLOW_T = 3;
  localparam int ALLRED_T = 2;
  localparam int PED_T    = 6;
  localparam int FLASH_T  = 4;

  logic          ck = 1'b0;
  logic          rs = 1'b1;
  logic          ped_req = 1'b0;
  logic          night = 1'b0;
  logic [2:0]    light_ns, light_ew, state;
  logic          walk;
  logic [CW-1:0] counter;

  int n_vec = 0;
  int n_err = 0;

  tlc_intersection #(
    .CW(CW), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .PED_T(PED_T), .FLASH_T(FLASH_T)
  ) dut (
    .ck       (ck),
    .rs       (rs),
    .ped_req  (ped_req),
    .night    (night),
    .light_ns (light_ns),
    .light_ew (light_ew),
    .walk     (walk),
    .state    (state),
    .counter  (counter)
  );

  always #5 ck = ~ck;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phase name + time in phase) ----------
  tlc_state_e m_ph    = ST_AR1;
  int         m_t     = 0;
  bit         m_pend  = 1'b0;
  bit         m_walk  = 1'b0;
  bit         m_blink = 1'b1;
  bit         m_valid = 1'b0;

  function automatic int phase_len(input tlc_state_e p, input bit served);
    case (p)
      ST_NSG, ST_EWG: return GREEN_T;
      ST_NSY, ST_EWY: return YELLOW_T;
      ST_FLASH:       return FLASH_T;
      default:        return served ? PED_T : ALLRED_T;
    endcase
  endfunction

  function automatic logic [2:0] lamp_for(input tlc_state_e p, input bit blink, input bit ns_side);
    case (p)
      ST_NSG:   return ns_side ? 3'b001 : 3'b100;
      ST_NSY:   return ns_side ? 3'b010 : 3'b100;
      ST_EWG:   return ns_side ? 3'b100 : 3'b001;
      ST_EWY:   return ns_side ? 3'b100 : 3'b010;
      ST_FLASH: return blink ? 3'b010 : 3'b000;
      default:  return 3'b100;
    endcase
  endfunction

  task automatic model_step();
    bit         done;
    bit         req_seen;
    bit         to_ar;
    tlc_state_e nxt;
    if (rs) begin
      m_ph = ST_AR1; m_t = 0; m_pend = 1'b0; m_walk = 1'b0; m_blink = 1'b1;
      m_valid = 1'b1;
    end else begin
      req_seen = m_pend || ped_req;
      done     = (m_t == phase_len(m_ph, m_walk) - 1);
      nxt      = m_ph;
      case (m_ph)
        ST_AR1:   if (done) nxt = night ? ST_FLASH : ST_NSG;
        ST_NSG:   if (done || night) nxt = ST_NSY;
        ST_NSY:   if (done) nxt = ST_AR2;
        ST_AR2:   if (done) nxt = night ? ST_FLASH : ST_EWG;
        ST_EWG:   if (done || night) nxt = ST_EWY;
        ST_EWY:   if (done) nxt = ST_AR1;
        default:  if (!night) nxt = ST_AR1;
      endcase
      if (nxt != m_ph) begin
        to_ar  = (nxt == ST_AR1) || (nxt == ST_AR2);
        m_walk = to_ar && req_seen;
        m_pend = (to_ar || nxt == ST_FLASH) ? ped_req : req_seen;
        if (nxt == ST_FLASH) m_blink = 1'b1;
        m_ph = nxt;
        m_t  = 0;
      end else if (m_ph == ST_FLASH && done) begin
        m_t     = 0;
        m_blink = !m_blink;
        m_pend  = req_seen;
      end else begin
        m_t++;
        m_pend = req_seen;
      end
    end
  endtask

  initial forever begin
    @(posedge ck);
    model_step();
  end

  // Every-cycle comparison against the model, sampled on the falling edge
  initial forever begin
    @(negedge ck);
    if (m_valid) begin
      check("state",    state,   m_ph);
      check("counter",  counter, m_t);
      check("light_ns", light_ns, rs ? 3'b100 : lamp_for(m_ph, m_blink, 1'b1));
      check("light_ew", light_ew, rs ? 3'b100 : lamp_for(m_ph, m_blink, 1'b0));
      check("walk",     walk,    (!rs && m_walk) ? 1 : 0);
      if (m_ph != ST_FLASH)
        check("conflict", ((light_ns[1:0] != 2'b00) && (light_ew[1:0] != 2'b00)) ? 1 : 0, 0);
    end
  end

  // ---------------- directed scenarios -------------------------------------
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic wait_state(input tlc_state_e s, input string nm);
    int n = 0;
    while (state != s && n < 100) begin
      step();
      n++;
    end
    check({"reach_", nm}, state, s);
  endtask

  // Called on the first cycle of a phase; counts how many cycles it lasts
  task automatic measure(input tlc_state_e s, input int len, input bit w, input string nm);
    int n = 0;
    check({nm, "_state"}, state, s);
    check({nm, "_walk"}, walk, w);
    while (state == s && n < 40) begin
      step();
      n++;
    end
    check({nm, "_len"}, n, len);
  endtask

  initial begin
    // reset held for a few cycles
    rs = 1'b1;
    repeat (3) step();
    check("rst_ns",    light_ns, 3'b100);
    check("rst_ew",    light_ew, 3'b100);
    check("rst_walk",  walk, 0);
    check("rst_state", state, ST_AR1);
    check("rst_cnt",   counter, 0);
    rs = 1'b0;

    // normal cycle: 2+8+3+2+8+3 = 26
    measure(ST_AR1, 2, 1'b0, "n_ar1");
    measure(ST_NSG, 8, 1'b0, "n_nsg");
    measure(ST_NSY, 3, 1'b0, "n_nsy");
    measure(ST_AR2, 2, 1'b0, "n_ar2");
    measure(ST_EWG, 8, 1'b0, "n_ewg");
    measure(ST_EWY, 3, 1'b0, "n_ewy");
    measure(ST_AR1, 2, 1'b0, "n_ar1b");

    // one-cycle pedestrian pulse during NSG
    step(); step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_state(ST_NSY, "p_nsy");
    measure(ST_NSY, 3, 1'b0, "p_nsy");
    measure(ST_AR2, 6, 1'b1, "p_ar2");
    measure(ST_EWG, 8, 1'b0, "p_ewg");
    measure(ST_EWY, 3, 1'b0, "p_ewy");
    measure(ST_AR1, 2, 1'b0, "p_ar1");

    // request on the cycle that enters AR2
    wait_state(ST_NSY, "s_nsy");
    step(); step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    measure(ST_AR2, 6, 1'b1, "s_ar2");
    measure(ST_EWG, 8, 1'b0, "s_ewg");
    measure(ST_EWY, 3, 1'b0, "s_ewy");
    measure(ST_AR1, 6, 1'b1, "s_ar1");
    measure(ST_NSG, 8, 1'b0, "s_nsg");
    measure(ST_NSY, 3, 1'b0, "s_nsy2");
    measure(ST_AR2, 2, 1'b0, "s_ar2b");

    // night request at NSG counter 3
    wait_state(ST_NSG, "x_nsg");
    step(); step(); step();
    check("x_cnt3", counter, 3);
    night = 1'b1;
    step();
    check("x_nsy_now", state, ST_NSY);
    check("x_nsy_cnt", counter, 0);
    measure(ST_NSY, 3, 1'b0, "x_nsy");
    measure(ST_AR2, 2, 1'b0, "x_ar2");
    check("x_flash", state, ST_FLASH);
    for (int i = 0; i < 12; i++) begin
      check("x_blink_ns", light_ns, ((i / 4) % 2 == 0) ? 3'b010 : 3'b000);
      check("x_blink_ew", light_ew, ((i / 4) % 2 == 0) ? 3'b010 : 3'b000);
      step();
    end

    // leave night mode
    night = 1'b0;
    step();
    check("e_ar1_cnt", counter, 0);
    measure(ST_AR1, 2, 1'b0, "e_ar1");
    check("e_nsg", state, ST_NSG);

    // reset in the middle of EWG with a request pending
    wait_state(ST_EWG, "r_ewg");
    step(); step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    step(); step();
    check("r_cnt5", counter, 5);
    rs = 1'b1;
    #1;
    check("r_hold_ns",   light_ns, 3'b100);
    check("r_hold_ew",   light_ew, 3'b100);
    check("r_hold_walk", walk, 0);
    step();
    rs = 1'b0;
    #1;
    check("r_state", state, ST_AR1);
    check("r_cnt",   counter, 0);
    check("r_ns",    light_ns, 3'b100);
    check("r_ew",    light_ew, 3'b100);
    measure(ST_AR1, 2, 1'b0, "r_ar1");
    measure(ST_NSG, 8, 1'b0, "r_nsg");
    measure(ST_NSY, 3, 1'b0, "r_nsy");
    measure(ST_AR2, 2, 1'b0, "r_ar2");

    @(negedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
